regbus_initiator: RTL and testbench

Bus-side initiator for the 3-bit-address method interface (write_address/write_data/write_en/write_rdy, read_address/read_en/read_data/read_rdy) used by the register-mapped DUT. It takes single commands from a host over a valid/ready channel and drives exactly one write or read method call per command. Read results and completion status go back over a response channel. It sits between a test sequencer or CPU-side agent and the DUT, replacing hand-driven method pins. A per-transaction timeout guards against a DUT that never asserts rdy.

---
 rtl/regbus_initiator.sv | 123 ++++++++++++
 tb/tb_regbus_initiator.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regbus_initiator.sv
// Host-side initiator for the 3-bit-address write/read method interface.
// Accepts one command at a time, issues one method call, and returns a response.
module regbus_initiator #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_address,
  input  logic       cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_data,
  output logic       rsp_error,
  output logic       rsp_write,
  output logic [2:0] write_address,
  output logic       write_data,
  output logic       write_en,
  input  logic       write_rdy,
  output logic [2:0] read_address,
  output logic       read_en,
  input  logic       read_data,
  input  logic       read_rdy,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       addr_q, addr_d;
  logic             data_q, data_d;
  logic             rsp_data_q, rsp_data_d;
  logic             rsp_error_q, rsp_error_d;
  logic             rsp_write_q, rsp_write_d;
  logic             limit_hit;

  // A zero TIMEOUT never reaches the limit, so the command waits indefinitely.
  assign limit_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = rsp_error_q;
    rsp_write_d = rsp_write_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_address;
          data_d  = cmd_data;
          cnt_d   = '0;
          state_d = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (write_rdy || limit_hit) begin
          state_d     = RESP;
          rsp_data_d  = 1'b0;
          rsp_error_d = !write_rdy;
          rsp_write_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ: begin
        if (read_rdy || limit_hit) begin
          state_d     = RESP;
          rsp_data_d  = read_rdy ? read_data : 1'b0;
          rsp_error_d = !read_rdy;
          rsp_write_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= 1'b0;
      rsp_data_q  <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      rsp_write_q <= rsp_write_d;
    end
  end

  // Enables follow rdy directly but are masked by reset so nothing fires mid-reset.
  assign write_en      = (state_q == WRITE) && write_rdy && !RST;
  assign read_en       = (state_q == READ) && read_rdy && !RST;
  assign cmd_ready     = (state_q == IDLE) && !RST;
  assign busy          = (state_q != IDLE);
  assign rsp_valid     = (state_q == RESP);
  assign rsp_data      = rsp_data_q;
  assign rsp_error     = rsp_error_q;
  assign rsp_write     = rsp_write_q;
  assign write_address = addr_q;
  assign write_data    = data_q;
  assign read_address  = addr_q;

endmodule

// File: tb/tb_regbus_initiator.sv
// Bench for regbus_initiator: three instances (TIMEOUT 16, 4, 0) share one stimulus
// and are checked cycle by cycle against a transaction-level expectation.
module tb_regbus_initiator;

  logic       CLK = 1'b0;
  logic       RST;
  logic       cmd_valid, cmd_write, cmd_data, rsp_ready;
  logic [2:0] cmd_address;
  logic       write_rdy, read_rdy, read_data;

  logic [2:0] cmd_ready_v, rsp_valid_v, rsp_data_v, rsp_error_v, rsp_write_v;
  logic [2:0] write_data_v, write_en_v, read_en_v, busy_v;
  logic [2:0] waddr_v [3];
  logic [2:0] raddr_v [3];

  int total = 0;
  int bad   = 0;
  int txn_n = 0;

  int exp_c  [3];
  bit exp_e  [3];
  bit exp_rd [3];

  always #5 CLK = ~CLK;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    regbus_initiator #(
      .TIMEOUT((gi == 0) ? 16 : (gi == 1) ? 4 : 0),
      .CNT_W  (16)
    ) u_dut (
      .CLK          (CLK),
      .RST          (RST),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready_v[gi]),
      .cmd_write    (cmd_write),
      .cmd_address  (cmd_address),
      .cmd_data     (cmd_data),
      .rsp_valid    (rsp_valid_v[gi]),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data_v[gi]),
      .rsp_error    (rsp_error_v[gi]),
      .rsp_write    (rsp_write_v[gi]),
      .write_address(waddr_v[gi]),
      .write_data   (write_data_v[gi]),
      .write_en     (write_en_v[gi]),
      .write_rdy    (write_rdy),
      .read_address (raddr_v[gi]),
      .read_en      (read_en_v[gi]),
      .read_data    (read_data),
      .read_rdy     (read_rdy),
      .busy         (busy_v[gi])
    );
  end

  typedef struct {
    bit          w;
    logic [2:0]  a;
    bit          dt;
    logic [63:0] rdy;
    logic [63:0] rdm;
    int          rr;
    int          c16;
    bit          e16;
    bit          rd16;
    int          c4;
    bit          e4;
    bit          rd4;
  } vec_t;

  function automatic int to_of(input int d);
    return (d == 0) ? 16 : (d == 1) ? 4 : 0;
  endfunction

  // Reference: the first rdy-high cycle k (1-based after accept) fires; if T cycles
  // pass with rdy low the command aborts on cycle T. Response appears one cycle later.
  function automatic void model(input int t, input logic [63:0] rdy, output int kf, output bit err);
    kf  = 63;
    err = 1'b1;
    for (int k = 1; k < 64; k++) begin
      if (rdy[k] == 1'b1) begin
        kf  = k;
        err = 1'b0;
        return;
      end
      if (t != 0 && k == t) begin
        kf  = k;
        err = 1'b1;
        return;
      end
    end
  endfunction

  task automatic chk(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0h want=%0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm, input bit ready_exp);
    for (int d = 0; d < 3; d++) begin
      chk({nm, "_cmd_ready"}, d, 8'(cmd_ready_v[d]), 8'(ready_exp));
      chk({nm, "_busy"}, d, 8'(busy_v[d]), 8'h0);
      chk({nm, "_rsp_valid"}, d, 8'(rsp_valid_v[d]), 8'h0);
      chk({nm, "_rsp_fields"}, d, 8'({rsp_data_v[d], rsp_error_v[d], rsp_write_v[d]}), 8'h0);
      chk({nm, "_en"}, d, 8'({write_en_v[d], read_en_v[d]}), 8'h0);
      chk({nm, "_dut_bus"}, d, 8'({waddr_v[d], raddr_v[d], write_data_v[d]}), 8'h0);
    end
  endtask

  // Expectations come from exp_c/exp_e/exp_rd; rsp_ready rises at cycle rr.
  task automatic run_txn(input bit w, input logic [2:0] a, input bit dt,
                         input logic [63:0] rdy, input logic [63:0] rdm, input int rr);
    int  r [3];
    int  rmin, rmax;
    bit  ev;
    rmin = 1000;
    rmax = 0;
    for (int d = 0; d < 3; d++) begin
      r[d] = (exp_c[d] > rr) ? exp_c[d] : rr;
      if (r[d] < rmin) rmin = r[d];
      if (r[d] > rmax) rmax = r[d];
    end
    cmd_valid   = 1'b1;
    cmd_write   = w;
    cmd_address = a;
    cmd_data    = dt;
    rsp_ready   = 1'b1;
    write_rdy   = 1'($urandom % 2);
    read_rdy    = 1'($urandom % 2);
    read_data   = 1'($urandom % 2);
    @(negedge CLK);
    for (int d = 0; d < 3; d++) begin
      chk("accept_ready", d, 8'(cmd_ready_v[d]), 8'h1);
      chk("idle_en", d, 8'({write_en_v[d], read_en_v[d]}), 8'h0);
    end
    @(posedge CLK); #1;
    for (int k = 1; k <= rmax + 1; k++) begin
      cmd_valid   = (k <= rmin) ? 1'($urandom % 2) : 1'b0;
      cmd_write   = 1'($urandom % 2);
      cmd_address = 3'($urandom % 8);
      cmd_data    = 1'($urandom % 2);
      if (w) begin
        write_rdy = rdy[k];
        read_rdy  = 1'($urandom % 2);
      end else begin
        read_rdy  = rdy[k];
        write_rdy = 1'($urandom % 2);
      end
      read_data = rdm[k];
      rsp_ready = (k >= rr);
      @(negedge CLK);
      for (int d = 0; d < 3; d++) begin
        ev = (k < exp_c[d]) && rdy[k];
        chk("write_en", d, 8'(write_en_v[d]), 8'(w && ev));
        chk("read_en", d, 8'(read_en_v[d]), 8'(!w && ev));
        chk("rsp_valid", d, 8'(rsp_valid_v[d]), 8'(k >= exp_c[d] && k <= r[d]));
        chk("cmd_ready", d, 8'(cmd_ready_v[d]), 8'(k > r[d]));
        chk("busy", d, 8'(busy_v[d]), 8'(k <= r[d]));
        chk("dut_addr", d, 8'({waddr_v[d], raddr_v[d]}), 8'({a, a}));
        chk("write_data", d, 8'(write_data_v[d]), 8'(dt));
        if (k >= exp_c[d] && k <= r[d]) begin
          chk("rsp_error", d, 8'(rsp_error_v[d]), 8'(exp_e[d]));
          chk("rsp_write", d, 8'(rsp_write_v[d]), 8'(w));
          chk("rsp_data", d, 8'(rsp_data_v[d]), 8'(exp_rd[d]));
        end
      end
      @(posedge CLK); #1;
    end
    txn_n++;
    $display("txn %0d: %s addr=%0d rsp_cycle=%0d/%0d/%0d err=%0d/%0d/%0d",
             txn_n, w ? "write" : "read ", a, exp_c[0], exp_c[1], exp_c[2],
             exp_e[0], exp_e[1], exp_e[2]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t        tv [9];
    logic [63:0] rrdy, rrdm;
    bit          rw, re;
    int          rr, kf;

    tv[0] = '{1'b1, 3'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 2, 1'b0, 1'b0, 2, 1'b0, 1'b0};
    tv[1] = '{1'b0, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 2, 1'b0, 1'b1, 2, 1'b0, 1'b1};
    tv[2] = '{1'b1, 3'd1, 1'b0, ~64'h3F, 64'h0, 0, 7, 1'b0, 1'b0, 5, 1'b1, 1'b0};
    tv[3] = '{1'b0, 3'd7, 1'b1, 64'h0000_0000_0010_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 17, 1'b1, 1'b0, 5, 1'b1, 1'b0};
    tv[4] = '{1'b0, 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 12, 2, 1'b0, 1'b1, 2, 1'b0, 1'b1};
    tv[5] = '{1'b1, 3'd2, 1'b1, ~64'hF, 64'h0, 0, 5, 1'b0, 1'b0, 5, 1'b0, 1'b0};
    tv[6] = '{1'b0, 3'd6, 1'b0, 64'h5555_5555_5555_5554, ~64'h4, 0, 3, 1'b0, 1'b0, 3, 1'b0, 1'b0};
    tv[7] = '{1'b0, 3'd0, 1'b1, 64'h5555_5555_5555_5554, 64'h4, 0, 3, 1'b0, 1'b1, 3, 1'b0, 1'b1};
    tv[8] = '{1'b0, 3'd4, 1'b0, ~64'h1F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 6, 1'b0, 1'b1, 5, 1'b1, 1'b0};

    RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 3'd0; cmd_data = 1'b0;
    rsp_ready = 1'b0; write_rdy = 1'b1; read_rdy = 1'b1; read_data = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk_reset_vals("in_reset", 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_vals("after_reset", 1'b1);
    @(posedge CLK); #1;

    for (int i = 0; i < 9; i++) begin
      exp_c[0] = tv[i].c16; exp_e[0] = tv[i].e16; exp_rd[0] = tv[i].rd16;
      exp_c[1] = tv[i].c4;  exp_e[1] = tv[i].e4;  exp_rd[1] = tv[i].rd4;
      model(0, tv[i].rdy, kf, re);
      exp_c[2] = kf + 1; exp_e[2] = re; exp_rd[2] = (re || tv[i].w) ? 1'b0 : tv[i].rdm[kf];
      run_txn(tv[i].w, tv[i].a, tv[i].dt, tv[i].rdy, tv[i].rdm, tv[i].rr);
    end

    for (int n = 0; n < 40; n++) begin
      rrdy = '0;
      for (int k = 1; k < 64; k++) rrdy[k] = ($urandom_range(0, 3) == 0);
      rrdy[24] = 1'b1;
      rrdm = {$urandom, $urandom};
      rw   = 1'($urandom % 2);
      rr   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 0;
      for (int d = 0; d < 3; d++) begin
        model(to_of(d), rrdy, kf, re);
        exp_c[d]  = kf + 1;
        exp_e[d]  = re;
        exp_rd[d] = (re || rw) ? 1'b0 : rrdm[kf];
      end
      run_txn(rw, 3'($urandom % 8), 1'($urandom % 2), rrdy, rrdm, rr);
    end

    // Reset asserted while a write waits in WRITE with rdy high.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 3'd6; cmd_data = 1'b1;
    write_rdy = 1'b0; rsp_ready = 1'b1;
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
    @(negedge CLK);
    for (int d = 0; d < 3; d++) chk("midop_wait_busy", d, 8'({busy_v[d], write_en_v[d]}), 8'h2);
    @(posedge CLK); #1;
    RST = 1'b1; write_rdy = 1'b1;
    @(negedge CLK);
    for (int d = 0; d < 3; d++) begin
      chk("midop_rst_wen", d, 8'(write_en_v[d]), 8'h0);
      chk("midop_rst_ready", d, 8'(cmd_ready_v[d]), 8'h0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_vals("midop_after", 1'b1);
    for (int j = 0; j < 3; j++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      for (int d = 0; d < 3; d++) chk("midop_no_rsp", d, 8'({rsp_valid_v[d], busy_v[d]}), 8'h0);
    end
    $display("txn %0d: write addr=6 aborted by reset", ++txn_n);

    // Reset while a read response is pending.
    @(posedge CLK); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 3'd2; read_rdy = 1'b0; rsp_ready = 1'b0;
    @(posedge CLK); #1;
    cmd_valid = 1'b0; read_rdy = 1'b1; read_data = 1'b1;
    @(posedge CLK); #1;
    read_data = 1'b0;
    @(negedge CLK);
    for (int d = 0; d < 3; d++) chk("resp_pending", d, 8'({rsp_valid_v[d], rsp_data_v[d]}), 8'h3);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    for (int d = 0; d < 3; d++) begin
      chk("resp_rst_valid", d, 8'({rsp_valid_v[d], rsp_data_v[d]}), 8'h0);
      chk("resp_rst_ready", d, 8'(cmd_ready_v[d]), 8'h1);
    end
    $display("txn %0d: read addr=2 response discarded by reset", ++txn_n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
